// File: rtl/matrix_readout_pkg.sv
// Shared types and sizing helpers for the matrix read-side scheduler.
// Pure declarations: no latency and no backpressure of its own.
package matrix_readout_pkg;

   typedef enum logic [2:0] {IDLE, SWAP, SCAN, DRAIN, GAP} readout_state_t;

   localparam logic [15:0] STAT_MAX = 16'hFFFF;

   // Never returns 0, so a one-entry space still gets a legal 1-bit vector.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int fifo_depth(input int read_latency);
      return read_latency + 1;
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/matrix_readout_scheduler_skid_fifo.sv
// Small synchronous FIFO catching buffer read data; a push is visible on pop_vld the next cycle.
// Pops on pop_vld && pop_rdy; free_cnt lets the issuer throttle so pushes never meet a full FIFO.
module readout_skid_fifo
   import matrix_readout_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int WIDTH = 8,
   localparam int CW = count_width(DEPTH),
   localparam int PW = addr_width(DEPTH)
) (
   input  logic             core_clk,
   input  logic             arst_n,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop_rdy,
   output logic             pop_vld,
   output logic [WIDTH-1:0] pop_dat,
   output logic [CW-1:0]    free_cnt
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign pop_vld  = (count != '0);
   assign do_pop   = pop_vld && pop_rdy;
   assign do_push  = push_vld && ((count != CW'(DEPTH)) || do_pop);
   assign free_cnt = CW'(DEPTH) - count;
   assign pop_dat  = mem[rd_ptr];

   always_ff @(posedge core_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/matrix_readout_scheduler.sv
// Read-side double-buffer scanner: first byte valid READ_LATENCY+1 cycles after O_frame_start, one byte/cycle.
// Credit-throttled reads absorb any I_byte_ready backpressure losslessly; counters need MATRIX_READOUT_STATS_EN.
module matrix_readout_scheduler
   import matrix_readout_pkg::*;
#(
   parameter int BYTES_PER_BLOCK    = 2250,
   parameter int BLOCK_DATA_WIDTH_B = 8,
   parameter int READ_LATENCY       = 2,
   parameter int FRAME_GAP_CYCLES   = 16,
   parameter int LANE_COUNT         = 1,
   localparam int ADDRESS_NUMBER_B  = (BYTES_PER_BLOCK * 8) / BLOCK_DATA_WIDTH_B,
   localparam int AW                = addr_width(ADDRESS_NUMBER_B),
   localparam int DW                = BLOCK_DATA_WIDTH_B * LANE_COUNT
) (
   input  logic          I_clkb,
   input  logic          I_rst_n,
   input  logic          I_data_valid,
   input  logic          I_frame_ready,
   output logic          O_swap_trigger,
   output logic [AW-1:0] O_read_address,
   output logic          O_clk_data_out,
   input  logic [DW-1:0] I_read_data,
   output logic          O_byte_valid,
   output logic [DW-1:0] O_byte_data,
   input  logic          I_byte_ready,
   output logic          O_frame_start,
   output logic          O_frame_done,
   output logic [15:0]   O_frame_count,
   output logic [15:0]   O_drop_count
);

   localparam int DEPTH = fifo_depth(READ_LATENCY);
   localparam int CW    = count_width(DEPTH);
   localparam int GW    = addr_width(FRAME_GAP_CYCLES);

   readout_state_t          state;
   logic [AW-1:0]           addr;
   logic [READ_LATENCY-1:0] issue_pipe;
   logic [GW-1:0]           gap_cnt;
   logic                    swap_pending;
   logic [CW-1:0]           free_cnt;
   logic [CW:0]             inflight;
   logic [CW:0]             headroom;
   logic [DW-1:0]           fifo_dat;
   logic                    push;
   logic                    pop;
   logic                    issue;
   logic                    last_addr;
   logic                    drained;

   assign push = issue_pipe[READ_LATENCY-1];
   assign pop  = O_byte_valid && I_byte_ready;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + (CW+1)'(issue_pipe[i]);
      end
   end

   // A slot freed by this cycle's pop counts as credit; that keeps full rate at depth READ_LATENCY+1.
   assign headroom  = {1'b0, free_cnt} + (CW+1)'(pop);
   assign issue     = (state == SCAN) && (headroom > inflight);
   assign last_addr = (addr == AW'(ADDRESS_NUMBER_B - 1));
   assign drained   = (issue_pipe == '0) &&
                      ((free_cnt == CW'(DEPTH)) || (pop && (free_cnt == CW'(DEPTH - 1))));

   assign O_clk_data_out = issue;
   assign O_read_address = addr;
   assign O_byte_data    = O_byte_valid ? fifo_dat : '0;

   always_ff @(posedge I_clkb or negedge I_rst_n) begin
      if (!I_rst_n) begin
         issue_pipe <= '0;
      end else begin
         issue_pipe <= (issue_pipe << 1) | READ_LATENCY'(issue);
      end
   end

   always_ff @(posedge I_clkb or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state          <= IDLE;
         addr           <= '0;
         gap_cnt        <= '0;
         swap_pending   <= 1'b0;
         O_swap_trigger <= 1'b0;
         O_frame_start  <= 1'b0;
         O_frame_done   <= 1'b0;
      end else begin
         O_swap_trigger <= 1'b0;
         O_frame_start  <= 1'b0;
         O_frame_done   <= 1'b0;
         // A frame landing during SWAP belongs to the other buffer, so it re-arms the request.
         if (I_frame_ready) begin
            swap_pending <= 1'b1;
         end else if (state == SWAP) begin
            swap_pending <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (swap_pending) begin
                  state          <= SWAP;
                  O_swap_trigger <= 1'b1;
               end else if (I_data_valid) begin
                  state         <= SCAN;
                  addr          <= '0;
                  O_frame_start <= 1'b1;
               end
            end
            SWAP: begin
               state         <= SCAN;
               addr          <= '0;
               O_frame_start <= 1'b1;
            end
            SCAN: begin
               if (issue) begin
                  if (last_addr) begin
                     state <= DRAIN;
                  end else begin
                     addr <= addr + AW'(1);
                  end
               end
            end
            DRAIN: begin
               if (drained) begin
                  state        <= GAP;
                  gap_cnt      <= '0;
                  O_frame_done <= 1'b1;
               end
            end
            GAP: begin
               if (gap_cnt == GW'(FRAME_GAP_CYCLES - 1)) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   readout_skid_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DW)
   ) u_skid_fifo (
      .core_clk (I_clkb),
      .arst_n   (I_rst_n),
      .push_vld (push),
      .push_dat (I_read_data),
      .pop_rdy  (I_byte_ready),
      .pop_vld  (O_byte_valid),
      .pop_dat  (fifo_dat),
      .free_cnt (free_cnt)
   );

`ifdef MATRIX_READOUT_STATS_EN
   logic drop;

   assign drop = I_frame_ready && swap_pending && (state != SWAP);

   always_ff @(posedge I_clkb or negedge I_rst_n) begin
      if (!I_rst_n) begin
         O_frame_count <= '0;
         O_drop_count  <= '0;
      end else begin
         if (O_frame_done && (O_frame_count != STAT_MAX)) begin
            O_frame_count <= O_frame_count + 16'd1;
         end
         if (drop && (O_drop_count != STAT_MAX)) begin
            O_drop_count <= O_drop_count + 16'd1;
         end
      end
   end
`else
   assign O_frame_count = '0;
   assign O_drop_count  = '0;
`endif

endmodule

// File: tb/tb_matrix_readout_scheduler.sv
// Bench for matrix_readout_scheduler: 16-address frames, read latency 2, 4-cycle gap.
module tb_matrix_readout_scheduler;

   localparam int NA = 16;
   localparam int L  = 2;
   localparam int G  = 4;
`ifdef MATRIX_READOUT_STATS_EN
   localparam int STATS_EN = 1;
`else
   localparam int STATS_EN = 0;
`endif

   typedef struct {
      int mode;       // 0 ready held high, 1 random ready, 2 alternating ready
      int pulses;     // I_frame_ready pulses issued during the scan
      int exp_swap;   // swap expected before the following frame
      int exp_drop;   // drop_count increase expected from this frame
   } vec_t;

   logic        clk = 1'b0;
   logic        I_rst_n = 1'b0;
   logic        I_data_valid = 1'b0;
   logic        I_frame_ready = 1'b0;
   logic        I_byte_ready = 1'b1;
   logic [7:0]  mem_q0 = 8'h00;
   logic [7:0]  mem_q1 = 8'h00;
   logic        O_swap_trigger;
   logic [3:0]  O_read_address;
   logic        O_clk_data_out;
   logic        O_byte_valid;
   logic [7:0]  O_byte_data;
   logic        O_frame_start;
   logic        O_frame_done;
   logic [15:0] O_frame_count;
   logic [15:0] O_drop_count;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int gen = 0;
   int n_swap = 0, n_start = 0, n_done = 0;
   int last_swap_cyc = 0, last_start_cyc = 0, last_done_cyc = 0;
   int first_valid_cyc = -1, first_acc_cyc = -1, last_acc_cyc = 0;
   int addr_q[$];
   int byte_q[$];

   matrix_readout_scheduler #(
      .BYTES_PER_BLOCK    (16),
      .BLOCK_DATA_WIDTH_B (8),
      .READ_LATENCY       (L),
      .FRAME_GAP_CYCLES   (G),
      .LANE_COUNT         (1)
   ) dut (
      .I_clkb         (clk),
      .I_rst_n        (I_rst_n),
      .I_data_valid   (I_data_valid),
      .I_frame_ready  (I_frame_ready),
      .O_swap_trigger (O_swap_trigger),
      .O_read_address (O_read_address),
      .O_clk_data_out (O_clk_data_out),
      .I_read_data    (mem_q1),
      .O_byte_valid   (O_byte_valid),
      .O_byte_data    (O_byte_data),
      .I_byte_ready   (I_byte_ready),
      .O_frame_start  (O_frame_start),
      .O_frame_done   (O_frame_done),
      .O_frame_count  (O_frame_count),
      .O_drop_count   (O_drop_count)
   );

   always #5 clk = ~clk;

   // Two-stage buffer model; the content tag is the number of swaps the buffer has seen.
   always @(posedge clk) begin
      mem_q0 <= O_clk_data_out ? 8'((gen % 16) * 16 + int'(O_read_address)) : 8'hEE;
      mem_q1 <= mem_q0;
   end

   always @(negedge clk) begin
      cyc++;
      if (O_swap_trigger) begin
         n_swap++;
         last_swap_cyc = cyc;
         gen++;
      end
      if (O_frame_start) begin
         n_start++;
         last_start_cyc = cyc;
         first_valid_cyc = -1;
         first_acc_cyc = -1;
      end
      if (O_frame_done) begin
         n_done++;
         last_done_cyc = cyc;
      end
      if (O_clk_data_out) addr_q.push_back(int'(O_read_address));
      if (O_byte_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (O_byte_valid && I_byte_ready) begin
         byte_q.push_back(int'(O_byte_data));
         if (first_acc_cyc < 0) first_acc_cyc = cyc;
         last_acc_cyc = cyc;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic wait_start(input string name, input int n0);
      int k = 0;
      while (n_start == n0 && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      chk({name, "_start_seen"}, n_start - n0, 1);
   endtask

   task automatic drive_frame(input string name, input int mode, input int pulses, input int n0);
      int k = 0;
      while (n_done == n0 && k < 400) begin
         if (mode == 0) I_byte_ready = 1'b1;
         else if (mode == 1) I_byte_ready = ($urandom_range(0, 1) == 1);
         else I_byte_ready = ((k % 2) == 0);
         I_frame_ready = (k == 2 && pulses > 0) || (k == 5 && pulses > 1) || (k == 8 && pulses > 2);
         @(posedge clk); #1;
         k++;
      end
      I_frame_ready = 1'b0;
      I_byte_ready = 1'b1;
      chk({name, "_done_seen"}, n_done - n0, 1);
   endtask

   task automatic check_frame(input string name, input int exp_gen_v, input int mode);
      int errs;
      chk({name, "_addr_count"}, addr_q.size(), NA);
      errs = 0;
      foreach (addr_q[i]) if (addr_q[i] != i) errs++;
      chk({name, "_addr_order"}, errs, 0);
      chk({name, "_byte_count"}, byte_q.size(), NA);
      errs = 0;
      foreach (byte_q[i]) if (byte_q[i] != (exp_gen_v % 16) * 16 + (i % 16)) errs++;
      chk({name, "_byte_data"}, errs, 0);
      chk({name, "_done_after_last_accept"}, last_done_cyc - last_acc_cyc, 1);
      if (mode == 0) begin
         chk({name, "_first_byte_latency"}, first_valid_cyc - last_start_cyc, L + 1);
         chk({name, "_burst_span"}, last_acc_cyc - first_acc_cyc, NA - 1);
      end
   endtask

   task automatic clear_queues();
      addr_q.delete();
      byte_q.delete();
   endtask

   initial begin
      vec_t vecs[8];
      int exp_gen, exp_frames, exp_drops, pend_exp, fr_cyc, found;
      int d, ns0, nsw0, nd0;
      vecs[0] = '{0, 0, 0, 0};
      vecs[1] = '{1, 0, 0, 0};
      vecs[2] = '{0, 1, 1, 0};
      vecs[3] = '{1, 2, 1, 1};
      vecs[4] = '{2, 1, 1, 0};
      vecs[5] = '{1, 3, 1, 2};
      vecs[6] = '{1, 0, 0, 0};
      vecs[7] = '{0, 0, 0, 0};

      // Reset state and quiescent idle without a displayable frame.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs_zero",
          int'({O_swap_trigger, O_read_address, O_clk_data_out, O_byte_valid, O_byte_data,
                O_frame_start, O_frame_done, O_frame_count, O_drop_count} != '0), 0);
      @(posedge clk); #1;
      I_rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("idle_no_frame_start", n_start, 0);
      chk("idle_no_reads", addr_q.size(), 0);

      // First frame arrives: one swap, then a scan of the new buffer.
      I_frame_ready = 1'b1;
      fr_cyc = cyc + 1;
      @(posedge clk); #1;
      I_frame_ready = 1'b0;
      I_data_valid = 1'b1;
      wait_start("first", 0);
      chk("first_swap_once", n_swap, 1);
      chk("first_swap_timing", last_swap_cyc - fr_cyc, 2);
      chk("first_swap_to_start", last_start_cyc - last_swap_cyc, 1);
      exp_gen = 1;
      drive_frame("frame0", 0, 0, 0);
      check_frame("frame0", exp_gen, 0);
      exp_frames = 1;
      exp_drops = 0;
      pend_exp = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("frame0_frame_count", int'(O_frame_count), STATS_EN * exp_frames);
      clear_queues();

      for (int r = 0; r < 8; r++) begin
         string nm;
         nm = $sformatf("row%0d", r);
         d = last_done_cyc;
         ns0 = n_start;
         nsw0 = n_swap;
         nd0 = n_done;
         wait_start(nm, ns0);
         chk({nm, "_gap"}, last_start_cyc - d, G + 1 + pend_exp);
         chk({nm, "_swaps"}, n_swap - nsw0, pend_exp);
         exp_gen += pend_exp;
         drive_frame(nm, vecs[r].mode, vecs[r].pulses, nd0);
         check_frame(nm, exp_gen, vecs[r].mode);
         pend_exp = vecs[r].exp_swap;
         exp_drops += vecs[r].exp_drop;
         exp_frames++;
         repeat (2) @(posedge clk);
         #1;
         chk({nm, "_frame_count"}, int'(O_frame_count), STATS_EN * exp_frames);
         chk({nm, "_drop_count"}, int'(O_drop_count), STATS_EN * exp_drops);
         clear_queues();
      end

      // Reset in the middle of a scan, then a clean restart from address 0.
      ns0 = n_start;
      nsw0 = n_swap;
      wait_start("abort", ns0);
      found = 0;
      for (int k = 0; k < 40 && found == 0; k++) begin
         @(negedge clk);
         if (O_clk_data_out && O_read_address == 4'd7) found = 1;
      end
      chk("abort_reached_addr7", found, 1);
      nd0 = n_done;
      #1;
      I_rst_n = 1'b0;
      #1;
      chk("abort_async_outputs_zero",
          int'({O_swap_trigger, O_read_address, O_clk_data_out, O_byte_valid, O_byte_data,
                O_frame_start, O_frame_done, O_frame_count, O_drop_count} != '0), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_frame_done", n_done - nd0, 0);
      clear_queues();
      ns0 = n_start;
      I_rst_n = 1'b1;
      wait_start("restart", ns0);
      chk("restart_first_addr", (addr_q.size() > 0) ? addr_q[0] : -1, 0);
      drive_frame("restart", 0, 0, n_done);
      check_frame("restart", exp_gen, 0);
      chk("restart_no_swap", n_swap - nsw0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("restart_frame_count", int'(O_frame_count), STATS_EN);
      chk("restart_drop_count", int'(O_drop_count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
